// File: rtl/imem_pkg.sv
// imem_pkg: shared states and field widths for the instruction-memory boot loader.
package imem_pkg;
  localparam int IMEM_LEN_W          = 16;
  localparam int IMEM_BYTES_PER_WORD = 4;
  typedef enum logic [2:0] {
    ST_IDLE, ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_WRITE, ST_CHECK, ST_DONE, ST_ERR
  } imem_loader_state_t;
endpackage

// File: rtl/imem_word_assembler.sv
// imem_word_assembler: packs accepted bytes little-endian into a 32-bit word.
module imem_word_assembler
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_done
);
  logic [1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt  <= '0;
      word <= '0;
    end else if (clr) begin
      cnt  <= '0;
      word <= '0;
    end else if (en) begin
      cnt  <= cnt + 2'd1;
      word <= {data, word[31:8]};
    end
  // shifting in from the top leaves byte k in lane k once the fourth byte lands
  always_comb word_done = en && (cnt == 2'(IMEM_BYTES_PER_WORD - 1));
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed image into instruction memory while holding the core.
// IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte verified in a CHECK state.
module imem_loader
  import imem_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int MAX_WORDS = MEM_BYTES / 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_hold
);
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam imem_loader_state_t ST_FIN = ST_CHECK;
`else
  localparam imem_loader_state_t ST_FIN = ST_DONE;
`endif
  imem_loader_state_t state, state_nxt;
  logic [IMEM_LEN_W-1:0] len, word_idx, len_new;
  logic [31:0] word;
  logic accept, go, asm_en, word_done;
  assign accept  = s_valid && s_ready;
  assign go      = (state == ST_IDLE) && start;
  assign asm_en  = accept && (state == ST_DATA);
  assign len_new = {s_data, len[7:0]};
  imem_word_assembler u_asm (
    .clk(clk), .rst_n(rst_n), .clr(go), .en(asm_en), .data(s_data),
    .word(word), .word_done(word_done)
  );
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) csum <= '0;
    else csum <= go ? 8'h00 : asm_en ? csum ^ s_data : csum;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   state_nxt = start ? ST_LEN_LO : ST_IDLE;
      ST_LEN_LO: state_nxt = accept ? ST_LEN_HI : ST_LEN_LO;
      ST_LEN_HI: state_nxt = !accept ? ST_LEN_HI :
                             (len_new == '0) ? ST_FIN :
                             ({1'b0, len_new} > 17'(MAX_WORDS)) ? ST_ERR : ST_DATA;
      ST_DATA:   state_nxt = word_done ? ST_WRITE : ST_DATA;
      ST_WRITE:  state_nxt = (word_idx + 16'd1 == len) ? ST_FIN : ST_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK:  state_nxt = !accept ? ST_CHECK : (s_data == csum) ? ST_DONE : ST_ERR;
`endif
      default:   state_nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      len      <= '0;
      word_idx <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      if (go) begin
        len      <= '0;
        word_idx <= '0;
        done     <= 1'b0;
        error    <= 1'b0;
      end
      if (state_nxt == ST_DONE) done <= 1'b1;
      if (state_nxt == ST_ERR) error <= 1'b1;
      if (accept && state == ST_LEN_LO) len[7:0] <= s_data;
      if (accept && state == ST_LEN_HI) len[15:8] <= s_data;
      if (state == ST_WRITE) word_idx <= word_idx + 16'd1;
    end
  always_comb begin
    s_ready   = state inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHECK};
    busy      = !(state inside {ST_IDLE, ST_DONE, ST_ERR});
    cpu_hold  = busy;
    mem_we    = state == ST_WRITE;
    mem_addr  = {14'b0, word_idx, 2'b00};
    mem_wdata = word;
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader; expected writes queued as bytes are sent.
module tb_imem_loader;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic s_ready, mem_we, busy, done, error, cpu_hold;
  logic [31:0] mem_addr, mem_wdata;
  int n_checks = 0, n_pass = 0;
  logic [63:0] sb[$];
  logic [63:0] exp_w;
  logic [7:0] img[$];
  logic [7:0] cs_flip = 8'h00;
  always #5 clk = ~clk;
  imem_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask
  always @(negedge clk)
    if (rst_n && mem_we) begin
      if (sb.size() == 0) check("unexpected_we", 32'd1, 32'd0);
      else begin
        exp_w = sb.pop_front();
        check("we_addr", mem_addr, exp_w[63:32]);
        check("we_data", mem_wdata, exp_w[31:0]);
      end
    end
  task automatic send_byte(input logic [7:0] b, input bit toggle);
    int t = 0;
    if (toggle) begin
      s_valid = 1'b0;
      @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (t >= 64) check("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {31'b0, busy}, 32'd1);
  endtask
  task automatic load(input bit toggle, input int inject_at);
    logic [15:0] n = 16'(img.size() / 4);
    logic [7:0] cs = 8'h00;
    pulse_start();
    send_byte(n[7:0], toggle);
    send_byte(n[15:8], toggle);
    for (int i = 0; i < int'(n); i++) begin
      sb.push_back({32'(i * 4), img[4*i+3], img[4*i+2], img[4*i+1], img[4*i]});
      for (int k = 0; k < 4; k++) begin
        if (4 * i + k == inject_at) begin
          s_valid = 1'b0;
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
          check("start_ignored_busy", {31'b0, busy}, 32'd1);
        end
        send_byte(img[4*i+k], toggle);
        cs ^= img[4*i+k];
      end
      check("we_latency", {31'b0, mem_we}, 32'd1);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(cs ^ cs_flip, toggle);
`else
    cs ^= cs_flip;
`endif
    s_valid = 1'b0;
  endtask
  task automatic wait_end(input bit exp_err, input string tag);
    int t = 0;
    while (!done && !error && t < 64) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done"}, {31'b0, done}, {31'b0, !exp_err});
    check({tag, "_error"}, {31'b0, error}, {31'b0, exp_err});
    check({tag, "_cpu_hold"}, {31'b0, cpu_hold}, 32'd0);
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask
  task automatic rand_img(input int words);
    img.delete();
    for (int i = 0; i < 4 * words; i++) img.push_back(8'($urandom_range(0, 255)));
  endtask
  initial begin
    @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_error", {31'b0, error}, 32'd0);
    check("rst_we", {31'b0, mem_we}, 32'd0);
    check("rst_ready", {31'b0, s_ready}, 32'd0);
    check("rst_hold", {31'b0, cpu_hold}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    load(1'b0, -1);
    wait_end(1'b0, "n2_held");
    load(1'b1, -1);
    wait_end(1'b0, "n2_toggle");
    rand_img(256);
    load(1'b0, -1);
    wait_end(1'b0, "n256");
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    s_valid = 1'b0;
    check("n257_error", {31'b0, error}, 32'd1);
    check("n257_ready", {31'b0, s_ready}, 32'd0);
    check("n257_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    check("n257_sticky", {31'b0, error}, 32'd1);
    img.delete();
`ifdef IMEM_LOADER_CHECKSUM_EN
    load(1'b0, -1);
    wait_end(1'b0, "n0");
    img = '{8'h01, 8'h02, 8'h03, 8'h04};
    load(1'b0, -1);
    wait_end(1'b0, "csum_ok");
    cs_flip = 8'h01;
    load(1'b0, -1);
    wait_end(1'b1, "csum_bad");
    cs_flip = 8'h00;
`else
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    s_valid = 1'b0;
    check("n0_done", {31'b0, done}, 32'd1);
    check("n0_busy", {31'b0, busy}, 32'd0);
`endif
    rand_img(2);
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    sb.push_back({32'd0, img[3], img[2], img[1], img[0]});
    for (int k = 0; k < 6; k++) send_byte(img[k], 1'b0);
    s_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_hold", {31'b0, cpu_hold}, 32'd0);
    check("abort_we", {31'b0, mem_we}, 32'd0);
    check("abort_ready", {31'b0, s_ready}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_addr", mem_addr, 32'd0);
    check("abort_wdata", mem_wdata, 32'd0);
    check("abort_sb", 32'(sb.size()), 32'd0);
    rst_n = 1'b1;
    rand_img(3);
    load(1'b1, 5);
    wait_end(1'b0, "reload");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
